// File: rtl/bullets_manager.sv
// Player bullet pool: three slots with spawn, flight, explosion and
// per-pixel drawing request / colour generation.
module bullets_manager #(
  parameter int unsigned     BULLET_W        = 4,
  parameter int unsigned     BULLET_H        = 8,
  parameter int unsigned     SPEED           = 4,
  parameter int unsigned     X_OFFSET        = 14,
  parameter int unsigned     COOLDOWN_FRAMES = 8,
  parameter int unsigned     EXPLODE_FRAMES  = 6,
  parameter logic [7:0]      BULLET_COLOR    = 8'hFC,
  parameter logic [7:0]      EXPLODE_COLOR   = 8'hE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        fire,
  input  logic [10:0] shooterX,
  input  logic [10:0] shooterY,
  input  logic [2:0]  hit,
  output logic [2:0]  bulletDrawingRequest,
  output logic [7:0]  bulletRGB,
  output logic [1:0]  bulletsActive
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int EW = $clog2(EXPLODE_FRAMES + 1);
  localparam logic [CW-1:0] CD_LD  = CW'(COOLDOWN_FRAMES);
  localparam logic [EW-1:0] EXP_LD = EW'(EXPLODE_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_EXP} st_t;

  st_t           r_st [3];
  st_t           w_st_n [3];
  logic [10:0]   r_x [3];
  logic [10:0]   r_y [3];
  logic [10:0]   w_y_n [3];
  logic [10:0]   w_x_n [3];
  logic [EW-1:0] r_exp [3];
  logic [EW-1:0] w_exp_n [3];
  logic [CW-1:0] r_cool;
  logic          r_fireD;
  logic [2:0]    r_req;
  logic [7:0]    r_rgb;
  logic [1:0]    r_active;

  logic          w_edge;
  logic          w_has_idle;
  logic [1:0]    w_slot;
  logic          w_spawn;
  logic [10:0]   w_sx;
  logic [10:0]   w_sy;
  logic [1:0]    w_cnt;
  logic [2:0]    w_in;
  logic [7:0]    w_rgb;

  assign w_edge = fire & ~r_fireD;
  assign w_sx   = shooterX + 11'(X_OFFSET);
  assign w_sy   = (shooterY < 11'(BULLET_H)) ? 11'd0
                : shooterY - 11'(BULLET_H);

  // Lowest-index idle slot wins the spawn
  always_comb begin
    w_has_idle = 1'b0;
    w_slot     = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (r_st[i] == S_IDLE) begin
        w_has_idle = 1'b1;
        w_slot     = 2'(i);
      end
    end
  end

  assign w_spawn = w_edge && (r_cool == '0) && w_has_idle;

  always_comb begin
    w_cnt = 2'd0;
    for (int i = 0; i < 3; i++) begin
      w_st_n[i]  = r_st[i];
      w_x_n[i]   = r_x[i];
      w_y_n[i]   = r_y[i];
      w_exp_n[i] = r_exp[i];
      case (r_st[i])
        S_IDLE: begin
          if (w_spawn && w_slot == 2'(i)) begin
            w_st_n[i] = S_FLY;
            w_x_n[i]  = w_sx;
            w_y_n[i]  = w_sy;
          end
        end
        S_FLY: begin
          if (hit[i]) begin
            w_st_n[i]  = S_EXP;
            w_exp_n[i] = EXP_LD;
          end else if (startOfFrame) begin
            if (r_y[i] < 11'(SPEED)) w_st_n[i] = S_IDLE;
            else w_y_n[i] = r_y[i] - 11'(SPEED);
          end
        end
        S_EXP: begin
          if (startOfFrame) begin
            w_exp_n[i] = r_exp[i] - 1'b1;
            if (r_exp[i] == EW'(1)) w_st_n[i] = S_IDLE;
          end
        end
        default: w_st_n[i] = S_IDLE;
      endcase
      if (w_st_n[i] != S_IDLE) w_cnt = w_cnt + 2'd1;
    end
  end

  // 12-bit compares keep x + BULLET_W from wrapping at the right edge
  always_comb begin
    w_rgb = 8'h00;
    for (int i = 0; i < 3; i++) begin
      w_in[i] = (r_st[i] != S_IDLE)
        && ({1'b0, pixelX} >= {1'b0, r_x[i]})
        && ({1'b0, pixelX} <= {1'b0, r_x[i]} + 12'(BULLET_W - 1))
        && ({1'b0, pixelY} >= {1'b0, r_y[i]})
        && ({1'b0, pixelY} <= {1'b0, r_y[i]} + 12'(BULLET_H - 1));
    end
    for (int i = 2; i >= 0; i--) begin
      if (w_in[i])
        w_rgb = (r_st[i] == S_EXP) ? EXPLODE_COLOR : BULLET_COLOR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_st[i]  <= S_IDLE;
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_exp[i] <= '0;
      end
      r_cool   <= '0;
      r_fireD  <= 1'b0;
      r_req    <= '0;
      r_rgb    <= '0;
      r_active <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_st[i]  <= w_st_n[i];
        r_x[i]   <= w_x_n[i];
        r_y[i]   <= w_y_n[i];
        r_exp[i] <= w_exp_n[i];
      end
      if (w_spawn)
        r_cool <= CD_LD;
      else if (startOfFrame && r_cool != '0)
        r_cool <= r_cool - 1'b1;
      r_fireD  <= fire;
      r_req    <= w_in;
      r_rgb    <= w_rgb;
      r_active <= w_cnt;
    end
  end

  assign bulletDrawingRequest = r_req;
  assign bulletRGB            = r_rgb;
  assign bulletsActive        = r_active;

endmodule

// File: tb/tb_bullets_manager.sv
// Self-checking bench for bullets_manager: vector table plus
// hand-written multi-frame sequences, compared through a queue.
module tb_bullets_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
  logic [10:0] px, py, sx, sy;
  logic        fire;
  logic [2:0]  hit;
  logic [2:0]  req;
  logic [7:0]  rgb;
  logic [1:0]  act;

  bullets_manager dut (
    .clk                  (clk),
    .reset                (reset),
    .startOfFrame         (sof),
    .pixelX               (px),
    .pixelY               (py),
    .fire                 (fire),
    .shooterX             (sx),
    .shooterY             (sy),
    .hit                  (hit),
    .bulletDrawingRequest (req),
    .bulletRGB            (rgb),
    .bulletsActive        (act)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  req;
    logic [7:0]  rgb;
  } exp_t;

  typedef struct {
    string       nm;
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  req;
    logic [7:0]  rgb;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sofp(input int n);
    repeat (n) begin
      sof = 1'b1; tick();
      sof = 1'b0; tick();
    end
  endtask

  task automatic shoot();
    fire = 1'b1; tick();
    fire = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick();
    reset = 1'b0; tick();
  endtask

  task automatic probe(input string nm, input logic [10:0] x,
                       input logic [10:0] y, input logic [2:0] r,
                       input logic [7:0] c);
    exp_t e;
    px = x; py = y;
    e.nm = nm; e.req = r; e.rgb = c;
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    n_vec++;
    if (req !== e.req || rgb !== e.rgb) begin
      n_err++;
      $display("FAIL %s: req=%b rgb=%h, expected req=%b rgb=%h",
               e.nm, req, rgb, e.req, e.rgb);
    end
  endtask

  task automatic chk_act(input string nm, input logic [1:0] w);
    n_vec++;
    if (act !== w) begin
      n_err++;
      $display("FAIL %s: active=%0d, expected %0d", nm, act, w);
    end
  endtask

  task automatic chk_zero(input string nm);
    n_vec++;
    if (req !== 3'b000 || rgb !== 8'h00 || act !== 2'd0) begin
      n_err++;
      $display("FAIL %s: req=%b rgb=%h act=%0d, expected all 0",
               nm, req, rgb, act);
    end
  endtask

  initial begin
    tbl[0] = '{"spawn_tl",   11'd114, 11'd392, 3'b001, 8'hFC};
    tbl[1] = '{"spawn_br",   11'd117, 11'd399, 3'b001, 8'hFC};
    tbl[2] = '{"right_out",  11'd118, 11'd392, 3'b000, 8'h00};
    tbl[3] = '{"left_out",   11'd113, 11'd392, 3'b000, 8'h00};
    tbl[4] = '{"below_out",  11'd114, 11'd400, 3'b000, 8'h00};
    tbl[5] = '{"above_out",  11'd114, 11'd391, 3'b000, 8'h00};

    reset = 1'b1; sof = 1'b0; fire = 1'b0; hit = 3'b000;
    px = 11'd2047; py = 11'd2047; sx = 11'd100; sy = 11'd400;
    tick(); tick();
    chk_zero("reset_state");
    reset = 1'b0; tick();

    // Single shot and drawing window
    shoot();
    chk_act("one_spawn", 2'd1);
    for (int i = 0; i < 6; i++)
      probe(tbl[i].nm, tbl[i].x, tbl[i].y, tbl[i].req, tbl[i].rgb);

    // Held fire gives one shot; cooldown boundary
    do_reset();
    fire = 1'b1; tick();
    sofp(20);
    chk_act("hold_one", 2'd1);
    probe("hold_moved", 11'd114, 11'd312, 3'b001, 8'hFC);
    fire = 1'b0; tick();
    shoot();
    chk_act("slot1_spawn", 2'd2);
    sofp(3);
    shoot();
    chk_act("cool_drop3", 2'd2);
    sofp(4);
    shoot();
    chk_act("cool_drop7", 2'd2);
    sofp(1);
    shoot();
    chk_act("cool_ok8", 2'd3);
    sofp(8);
    shoot();
    chk_act("full_drop", 2'd3);

    // Retire off the top edge
    do_reset();
    sy = 11'd14; shoot();
    probe("y6", 11'd114, 11'd6, 3'b001, 8'hFC);
    sofp(1);
    probe("y2", 11'd114, 11'd2, 3'b001, 8'hFC);
    chk_act("y2_active", 2'd1);
    sofp(1);
    chk_act("retired", 2'd0);
    probe("retired_px", 11'd114, 11'd2, 3'b000, 8'h00);
    do_reset();
    sy = 11'd16; shoot();
    sofp(1);
    probe("y8_to_4", 11'd114, 11'd4, 3'b001, 8'hFC);
    probe("y4_bottom", 11'd114, 11'd12, 3'b000, 8'h00);
    chk_act("y4_active", 2'd1);
    do_reset();
    sy = 11'd5; sx = 11'd2040; shoot();
    probe("clamp_wrap", 11'd6, 11'd0, 3'b001, 8'hFC);
    probe("clamp_br", 11'd9, 11'd7, 3'b001, 8'hFC);
    sofp(1);
    chk_act("y0_retire", 2'd0);
    sx = 11'd100;

    // Hit together with frame pulse, then explosion lifetime
    do_reset();
    sy = 11'd208; shoot();
    hit = 3'b001; sof = 1'b1; tick();
    hit = 3'b000; sof = 1'b0; tick();
    probe("explode", 11'd114, 11'd200, 3'b001, 8'hE0);
    probe("frozen", 11'd114, 11'd199, 3'b000, 8'h00);
    hit = 3'b010; tick(); hit = 3'b000; tick();
    chk_act("idle_hit", 2'd1);
    sofp(5);
    chk_act("exp_5", 2'd1);
    sofp(1);
    chk_act("exp_6", 2'd0);

    // Overlap priority
    do_reset();
    sy = 11'd400; shoot();
    sofp(8);
    sy = 11'd372; shoot();
    probe("overlap", 11'd114, 11'd364, 3'b011, 8'hFC);
    sofp(8);
    sy = 11'd400; shoot();
    chk_act("three_act", 2'd3);
    hit = 3'b001; tick(); hit = 3'b000; tick();
    probe("ovl_exp", 11'd114, 11'd332, 3'b011, 8'hE0);
    probe("ovl_s1", 11'd114, 11'd338, 3'b010, 8'hFC);

    // Asynchronous reset mid-flight
    probe("pre_reset", 11'd114, 11'd332, 3'b011, 8'hE0);
    #3 reset = 1'b1;
    #1 chk_zero("async_reset");
    tick();
    reset = 1'b0; tick();
    sy = 11'd400; shoot();
    probe("post_reset", 11'd114, 11'd392, 3'b001, 8'hFC);
    chk_act("post_act", 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
